// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target/master state encodings and bus constants.
package i2c_pkg;
  localparam int   I2C_BITS_PER_BYTE = 8;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    T_IDLE, T_ADDR, T_ADDR_ACK, T_RX_BYTE, T_RX_ACK, T_TX_BYTE, T_TX_ACK, T_IGNORE
  } tgt_state_e;

  typedef enum logic [2:0] {
    M_IDLE, M_START, M_ADDR, M_WRITE, M_READ, M_ACK, M_STOP
  } mst_state_e;
endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with SCL edge and START/STOP condition detection.
module i2c_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);
  // [1:0] synchronizer, [2] history; reset to the idle-bus level
  logic [2:0] r_scl, r_sda;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl <= 3'b111;
      r_sda <= 3'b111;
    end else begin
      r_scl <= {r_scl[1:0], i_scl};
      r_sda <= {r_sda[1:0], i_sda};
    end
  end

  assign o_sda      = r_sda[1];
  assign o_scl_rise =  r_scl[1] & ~r_scl[2];
  assign o_scl_fall = ~r_scl[1] &  r_scl[2];
  assign o_start    =  r_scl[1] &  r_scl[2] & ~r_sda[1] &  r_sda[2];
  assign o_stop     =  r_scl[1] &  r_scl[2] &  r_sda[1] & ~r_sda[2];
endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: fixed address, register pointer, write bus and auto-increment read.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h29,
  parameter int         NUM_REGS   = 4,
  localparam int        PTR_W      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  inout  wire              scl_pin,
  inout  wire              sda_pin,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             busy
);
  localparam logic [3:0] LAST_BIT = 4'(I2C_BITS_PER_BYTE - 1);
  localparam logic [3:0] TX_ACKED = 4'(I2C_BITS_PER_BYTE);

  logic w_sda, w_rise, w_fall, w_start, w_stop;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_scl     (scl_pin),
    .i_sda     (sda_pin),
    .o_sda     (w_sda),
    .o_scl_rise(w_rise),
    .o_scl_fall(w_fall),
    .o_start   (w_start),
    .o_stop    (w_stop)
  );

  tgt_state_e       r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_sda_oe, w_sda_oe_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic             r_is_ptr, w_is_ptr_nxt;
  logic             r_wr_valid, w_wr_valid_nxt;
  logic [PTR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0]       r_wr_data, w_wr_data_nxt;
  logic             r_busy, w_busy_nxt;
  logic [7:0]       w_byte;

  assign w_byte = {r_shift[6:0], w_sda};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= T_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_sda_oe   <= 1'b0;
      r_ptr      <= '0;
      r_is_ptr   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_ptr      <= w_ptr_nxt;
      r_is_ptr   <= w_is_ptr_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_sda_oe_nxt   = r_sda_oe;
    w_ptr_nxt      = r_ptr;
    w_is_ptr_nxt   = r_is_ptr;
    w_wr_valid_nxt = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_busy_nxt     = r_busy;
    if (w_stop) begin
      w_state_nxt  = T_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_cnt_nxt    = '0;
    end else if (w_start) begin
      w_state_nxt  = T_ADDR;
      w_sda_oe_nxt = 1'b0;
      w_cnt_nxt    = '0;
    end else begin
      case (r_state)
        T_ADDR: if (w_rise) begin
          w_shift_nxt = w_byte;
          w_cnt_nxt   = r_cnt + 4'd1;
          if (r_cnt == LAST_BIT) begin
            w_cnt_nxt = '0;
            if (w_byte[7:1] == SLAVE_ADDR) begin
              w_state_nxt = T_ADDR_ACK;
              w_busy_nxt  = 1'b1;
            end else begin
              w_state_nxt = T_IGNORE;
            end
          end
        end
        // Output enable doubles as the ACK phase flag: first fall drives, second ends it.
        T_ADDR_ACK: if (w_fall) begin
          if (!r_sda_oe) w_sda_oe_nxt = 1'b1;
          else if (r_shift[0]) begin
            w_state_nxt  = T_TX_BYTE;
            w_shift_nxt  = rd_data;
            w_sda_oe_nxt = (rd_data[7] == ACK);
            w_cnt_nxt    = '0;
          end else begin
            w_state_nxt  = T_RX_BYTE;
            w_sda_oe_nxt = 1'b0;
            w_is_ptr_nxt = 1'b1;
          end
        end
        T_RX_BYTE: if (w_rise) begin
          w_shift_nxt = w_byte;
          w_cnt_nxt   = r_cnt + 4'd1;
          if (r_cnt == LAST_BIT) begin
            w_cnt_nxt   = '0;
            w_state_nxt = T_RX_ACK;
            if (r_is_ptr) begin
              w_ptr_nxt    = w_byte[PTR_W-1:0];
              w_is_ptr_nxt = 1'b0;
            end else begin
              w_wr_valid_nxt = 1'b1;
              w_wr_addr_nxt  = r_ptr;
              w_wr_data_nxt  = w_byte;
              w_ptr_nxt      = r_ptr + 1'b1;
            end
          end
        end
        T_RX_ACK: if (w_fall) begin
          if (!r_sda_oe) w_sda_oe_nxt = 1'b1;
          else begin
            w_sda_oe_nxt = 1'b0;
            w_state_nxt  = T_RX_BYTE;
          end
        end
        T_TX_BYTE: if (w_fall) begin
          if (r_cnt == LAST_BIT) begin
            w_sda_oe_nxt = 1'b0;
            w_state_nxt  = T_TX_ACK;
            w_cnt_nxt    = '0;
          end else begin
            w_shift_nxt  = {r_shift[6:0], 1'b0};
            w_sda_oe_nxt = (r_shift[6] == ACK);
            w_cnt_nxt    = r_cnt + 4'd1;
          end
        end
        // A count of 8 marks "master ACKed, load next byte on the coming fall".
        T_TX_ACK: begin
          if (w_rise && r_cnt == '0) begin
            w_ptr_nxt = r_ptr + 1'b1;
            if (w_sda == NACK) w_state_nxt = T_IGNORE;
            else               w_cnt_nxt   = TX_ACKED;
          end else if (w_fall && r_cnt == TX_ACKED) begin
            w_state_nxt  = T_TX_BYTE;
            w_shift_nxt  = rd_data;
            w_sda_oe_nxt = (rd_data[7] == ACK);
            w_cnt_nxt    = '0;
          end
        end
        T_IGNORE: begin
          w_sda_oe_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign sda_pin  = r_sda_oe ? 1'b0 : 1'bz;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign rd_addr  = r_ptr;
  assign busy     = r_busy;
endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C master with hand-computed expectations.
module tb_i2c_target;
  localparam time Q = 100ns;  // quarter SCL period; SCL period is 40 clk cycles

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tb_scl = 1'b1;
  logic       tb_sda = 1'b1;
  wire        scl_bus;
  wire        sda_bus;
  logic       wr_valid;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;

  logic [7:0] model [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};

  assign scl_bus = tb_scl;
  assign sda_bus = tb_sda ? 1'bz : 1'b0;
  pullup (sda_bus);
  assign rd_data = model[rd_addr];

  always #5ns clk = ~clk;

  i2c_target #(.SLAVE_ADDR(7'h29), .NUM_REGS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .scl_pin (scl_bus),
    .sda_pin (sda_bus),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  // Monitor: log write pulses, count target drives of a released line and busy-high cycles
  logic [1:0] wr_a [0:63];
  logic [7:0] wr_d [0:63];
  int wr_n = 0, drv_n = 0, bsy_n = 0;
  always @(negedge clk) begin
    if (wr_valid) begin
      wr_a[wr_n] <= wr_addr;
      wr_d[wr_n] <= wr_data;
      wr_n <= wr_n + 1;
    end
    if (tb_sda && !sda_bus) drv_n <= drv_n + 1;
    if (busy) bsy_n <= bsy_n + 1;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  task automatic i2c_start();
    tb_sda = 1'b1; #Q;
    tb_scl = 1'b1; #Q;
    tb_sda = 1'b0; #Q;
    tb_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    tb_sda = 1'b0; #Q;
    tb_scl = 1'b1; #Q;
    tb_sda = 1'b1; #Q;
  endtask

  // One SCL slot: drive, rise, sample mid-high, fall
  task automatic slot(input logic d, output logic s);
    tb_sda = d; #Q;
    tb_scl = 1'b1; #Q;
    s = sda_bus; #Q;
    tb_scl = 1'b0; #Q;
  endtask

  task automatic send(input logic [7:0] b, input string tag, input logic exp_ack);
    logic s;
    for (int i = 7; i >= 0; i--) slot(b[i], s);
    slot(1'b1, s);
    chk(tag, s, exp_ack);
  endtask

  task automatic recv(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      slot(1'b1, s);
      b[i] = s;
    end
    slot(mack, s);
    tb_sda = 1'b1;
  endtask

  initial begin
    logic [7:0] rb;
    int base, d0, b0;

    #50ns;
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_ptr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sda", sda_bus, 1);
    reset_n = 1'b1;
    #Q;

    // Write: pointer 1, then two data bytes
    base = wr_n;
    i2c_start();
    send(8'h52, "w_ack_addr", 1'b0);
    chk("w_busy", busy, 1);
    send(8'h01, "w_ack_ptr", 1'b0);
    send(8'hA5, "w_ack_d0", 1'b0);
    send(8'h3C, "w_ack_d1", 1'b0);
    chk("w_busy_pre_stop", busy, 1);
    i2c_stop();
    chk("w_busy_stop", busy, 0);
    chk("w_count", wr_n - base, 2);
    chk("w0_addr", wr_a[base], 1);
    chk("w0_data", wr_d[base], 8'hA5);
    chk("w1_addr", wr_a[base+1], 2);
    chk("w1_data", wr_d[base+1], 8'h3C);

    // Read: pointer 3, repeated START, two bytes with wrap
    i2c_start();
    send(8'h52, "r_ack_waddr", 1'b0);
    send(8'h03, "r_ack_ptr", 1'b0);
    i2c_start();
    send(8'h53, "r_ack_raddr", 1'b0);
    recv(1'b0, rb);
    chk("r_byte0", rb, 8'h44);
    recv(1'b1, rb);
    chk("r_byte1_wrap", rb, 8'h11);
    i2c_stop();
    chk("r_ptr_end", rd_addr, 1);
    chk("r_busy_end", busy, 0);

    // Reset while the target drives bit7=0 of 0x22
    i2c_start();
    send(8'h53, "rst_ack_raddr", 1'b0);
    chk("rst_tx_bit_low", sda_bus, 0);
    reset_n = 1'b0;
    #1ns;
    chk("rst_sda_release", sda_bus, 1);
    chk("rst_busy_mid", busy, 0);
    #(Q - 1ns);
    reset_n = 1'b1;
    tb_scl = 1'b1;
    #Q;
    base = wr_n;
    i2c_start();
    send(8'h52, "rw_ack_addr", 1'b0);
    send(8'h00, "rw_ack_ptr", 1'b0);
    send(8'h77, "rw_ack_d", 1'b0);
    i2c_stop();
    chk("rw_count", wr_n - base, 1);
    chk("rw_addr", wr_a[base], 0);
    chk("rw_data", wr_d[base], 8'h77);

    // Pointer byte upper bits are discarded
    base = wr_n;
    i2c_start();
    send(8'h52, "pu_ack_addr", 1'b0);
    send(8'hFE, "pu_ack_ptr", 1'b0);
    send(8'h9A, "pu_ack_d", 1'b0);
    i2c_stop();
    chk("pu_count", wr_n - base, 1);
    chk("pu_addr", wr_a[base], 2);
    chk("pu_data", wr_d[base], 8'h9A);

    // Address mismatch: no drive, no writes, never busy
    base = wr_n;
    d0 = drv_n;
    b0 = bsy_n;
    i2c_start();
    send(8'h54, "mm_nack_addr", 1'b1);
    send(8'hFF, "mm_nack_d", 1'b1);
    i2c_stop();
    chk("mm_sda_driven", drv_n - d0, 0);
    chk("mm_wr_count", wr_n - base, 0);
    chk("mm_busy", bsy_n - b0, 0);

    // Back-to-back transactions one SCL period apart
    base = wr_n;
    i2c_start();
    send(8'h52, "bb_ack_addr0", 1'b0);
    send(8'h01, "bb_ack_ptr0", 1'b0);
    send(8'h5A, "bb_ack_d0", 1'b0);
    i2c_stop();
    #(4 * Q);
    i2c_start();
    send(8'h52, "bb_ack_addr1", 1'b0);
    send(8'h02, "bb_ack_ptr1", 1'b0);
    send(8'h6B, "bb_ack_d1", 1'b0);
    i2c_stop();
    chk("bb_count", wr_n - base, 2);
    chk("bb0_addr", wr_a[base], 1);
    chk("bb0_data", wr_d[base], 8'h5A);
    chk("bb1_addr", wr_a[base+1], 2);
    chk("bb1_data", wr_d[base+1], 8'h6B);
    chk("bb_busy_end", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
